fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Single-clock read-side controller for the async FIFO read port. Issues ReadEn_out
//  only when Empty_in is low and buffer space is guaranteed. Captures FIFO data,
//  which appears one cycle after each read, into a 2-entry skid buffer. Presents
//  the data downstream as a valid/ready stream at full throughput, and counts
//  delivered words. Sits in the RClk domain between the FIFO and the consumer.
// PARAMETERS
//  DATA_WIDTH   32  width of FIFO words and of Data_out
//  COUNT_WIDTH  16  width of WordCount_out (wraps modulo 2**COUNT_WIDTH)
// PORTS
//  Clk            in   1            clock (same net as FIFO RClk)
//  Clear_in       in   1            reset: synchronous, active-high
//  Empty_in       in   1            FIFO Empty_out
//  ReadEn_out     out  1            FIFO ReadEn_in; combinational from Empty_in and state
//  FifoData_in    in   DATA_WIDTH   FIFO Data_out; valid the cycle after an accepted read
//  Data_out       out  DATA_WIDTH   downstream data (head of skid buffer, registered)
//  Valid_out      out  1            Data_out holds a word
//  Ready_in       in   1            downstream accepts word when Valid_out & Ready_in
//  WordCount_out  out  COUNT_WIDTH  number of words delivered (pops), wraps
// BEHAVIOUR
//  - Reset (Clear_in=1 at edge): Valid_out=0, Data_out=0, WordCount_out=0.
//    State=EMPTY and inflight=0; any in-flight FIFO word is discarded.
//    While Clear_in=1, ReadEn_out=0.
//  - Terms:
//    - pop = Valid_out & Ready_in.
//    - rd = ReadEn_out; every rd is a real FIFO read because rd implies ~Empty_in.
//    - inflight = registered rd from the previous cycle.
//  - State = buffer occupancy: EMPTY(0), ONE(1), TWO(2). Head = Data_out; tail = second register.
//  - ReadEn_out = ~Clear_in & ~Empty_in & (occ + inflight - pop < 2).
//    The buffer therefore never overflows.
//  - Each edge: if inflight, FifoData_in is captured.
//    - If the head becomes free (occ==0, or occ==1 with pop), it loads the head.
//    - Otherwise it loads the tail.
//    - On pop with occ==2, the tail moves to the head.
//  - Transitions (inflight=i, pop=p):
//    - EMPTY: i -> ONE; else EMPTY. (p impossible in EMPTY.)
//    - ONE: i&~p -> TWO; ~i&p -> EMPTY; else ONE (i&p: head reloads from FifoData_in).
//    - TWO: p&~i -> ONE; p&i -> TWO (tail->head, new->tail); ~p -> TWO (i impossible).
//  - Latency: a read sampled at edge N gives Valid_out=1 after edge N+1, when the buffer was empty.
//  - Throughput: 1 word/cycle sustained while ~Empty_in and Ready_in=1.
//  - Backpressure: Data_out and Valid_out hold stable while Valid_out & ~Ready_in.
//    Ordering is strict FIFO; no word is dropped or duplicated.
//  - WordCount_out increments by 1 on each pop; all-ones+1 wraps to 0.
//  - Empty_in rising mid-stream: reads stop immediately; buffered words still drain.
//  - Clear_in mid-operation overrides everything: buffered and in-flight words are lost.
// TESTING
//  1. Reset, Empty_in=1, 10 cycles -> ReadEn_out=0, Valid_out=0, WordCount_out=0.
//  2. Words 0xA0..0xA7 in FIFO, Ready_in=1:
//     - ReadEn_out high 8 cycles; first Valid_out one cycle after first read.
//     - Data_out 0xA0..0xA7 on consecutive cycles; WordCount_out=8.
//  3. 8 words, Ready_in=0 -> exactly 2 reads issued, state TWO, Data_out=0xA0 held;
//     - Ready_in=1 -> 0xA0..0xA7 in order, no gaps after restart, no loss.
//  4. Ready_in toggling 1/0 every cycle with 6 words -> all 6 delivered in order.
//     - ReadEn_out never asserted when occ+inflight-pop>=2.
//  5. COUNT_WIDTH=4, 17 words delivered -> WordCount_out wraps to 1.
//  6. Clear_in asserted the cycle after a read -> Valid_out=0 next cycle.
//     - The in-flight word never appears on Data_out; WordCount_out=0.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: issues reads, lands data in a 2-deep skid
// buffer and streams it out as valid/ready with a delivered-word counter.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Clear_in,
  input  logic                   Empty_in,
  output logic                   ReadEn_out,
  input  logic [DATA_WIDTH-1:0]  FifoData_in,
  output logic [DATA_WIDTH-1:0]  Data_out,
  output logic                   Valid_out,
  input  logic                   Ready_in,
  output logic [COUNT_WIDTH-1:0] WordCount_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            room;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] tail_nxt;

  assign Valid_out = (state != EMPTY);
  assign pop       = Valid_out & Ready_in;

  // Words owed to the buffer after this edge; pop implies occ>=1, no underflow
  assign room = {1'b0, state} + {2'b00, inflight} - {2'b00, pop};

  assign ReadEn_out = ~Clear_in & ~Empty_in & (room < 3'd2);

  always_comb begin
    state_nxt = state;
    head_nxt  = Data_out;
    tail_nxt  = tail;
    unique case (state)
      EMPTY: begin
        if (inflight) begin
          state_nxt = ONE;
          head_nxt  = FifoData_in;
        end
      end
      ONE: begin
        unique case (1'b1)
          (inflight & ~pop): begin
            state_nxt = TWO;
            tail_nxt  = FifoData_in;
          end
          (~inflight & pop): state_nxt = EMPTY;
          (inflight & pop):  head_nxt = FifoData_in;
          default:           state_nxt = ONE;
        endcase
      end
      TWO: begin
        if (pop) begin
          head_nxt = tail;
          if (inflight) tail_nxt  = FifoData_in;
          else          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      state         <= EMPTY;
      inflight      <= 1'b0;
      Data_out      <= '0;
      tail          <= '0;
      WordCount_out <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= ReadEn_out;
      Data_out <= head_nxt;
      tail     <= tail_nxt;
      if (pop) WordCount_out <= WordCount_out + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: FIFO model feeds reads, expected
// words are queued at read issue and compared on each downstream pop.
module tb_fifo_read_ctrl;

  logic        Clk = 1'b0;
  logic        Clear_in;
  logic        Empty_in;
  logic        Ready_in;
  logic [31:0] FifoData_in;
  logic        ReadEn_out;
  logic [31:0] Data_out;
  logic        Valid_out;
  logic [15:0] WordCount_out;
  logic        rd4;
  logic [31:0] d4;
  logic        v4;
  logic [3:0]  wc4;

  always #5 Clk = ~Clk;

  fifo_read_ctrl #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .Clk           (Clk),
    .Clear_in      (Clear_in),
    .Empty_in      (Empty_in),
    .ReadEn_out    (ReadEn_out),
    .FifoData_in   (FifoData_in),
    .Data_out      (Data_out),
    .Valid_out     (Valid_out),
    .Ready_in      (Ready_in),
    .WordCount_out (WordCount_out)
  );

  fifo_read_ctrl #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut4 (
    .Clk           (Clk),
    .Clear_in      (Clear_in),
    .Empty_in      (Empty_in),
    .ReadEn_out    (rd4),
    .FifoData_in   (FifoData_in),
    .Data_out      (d4),
    .Valid_out     (v4),
    .Ready_in      (Ready_in),
    .WordCount_out (wc4)
  );

  int          nvec;
  int          nerr;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          cyc_n;
  int          nreads;
  int          npops;
  int          first_rd;
  int          first_pop;
  int          last_pop;
  logic        hold_prev;
  logic [31:0] data_prev;
  logic [31:0] pend;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_stats();
    cyc_n     = 0;
    nreads    = 0;
    npops     = 0;
    first_rd  = -1;
    first_pop = -1;
    last_pop  = -1;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
    Empty_in = (fifo_q.size() == 0);
  endtask

  task automatic cyc();
    logic p;
    logic r;
    @(negedge Clk);
    p = Valid_out & Ready_in;
    r = ReadEn_out;
    if (Clear_in) check("rden_clr", {31'd0, ReadEn_out}, 32'd0);
    if (hold_prev) begin
      check("hold_v", {31'd0, Valid_out}, 32'd1);
      check("hold_d", Data_out, data_prev);
    end
    hold_prev = Valid_out & ~Ready_in & ~Clear_in;
    data_prev = Data_out;
    if (p) begin
      if (exp_q.size() == 0) check("spurious", 32'd1, 32'd0);
      else check("data", Data_out, exp_q.pop_front());
      npops++;
      if (first_pop < 0) first_pop = cyc_n;
      last_pop = cyc_n;
    end
    if (r) begin
      if (fifo_q.size() == 0) begin
        check("rd_empty", 32'd1, 32'd0);
      end else begin
        pend = fifo_q.pop_front();
        exp_q.push_back(pend);
      end
      nreads++;
      if (first_rd < 0) first_rd = cyc_n;
      check("ovf", {31'd0, exp_q.size() <= 2}, 32'd1);
    end
    cyc_n++;
    @(posedge Clk);
    #1;
    if (Clear_in) exp_q.delete();
    FifoData_in = r ? pend : $urandom();
    Empty_in    = (fifo_q.size() == 0);
  endtask

  task automatic do_clear();
    Clear_in = 1'b1;
    cyc();
    Clear_in = 1'b0;
  endtask

  initial begin
    nvec        = 0;
    nerr        = 0;
    hold_prev   = 1'b0;
    data_prev   = '0;
    pend        = '0;
    Clear_in    = 1'b1;
    Empty_in    = 1'b1;
    Ready_in    = 1'b0;
    FifoData_in = '0;
    reset_stats();

    // reset state and idle with empty FIFO
    cyc();
    cyc();
    Clear_in = 1'b0;
    check("rst_valid", {31'd0, Valid_out}, 32'd0);
    check("rst_data", Data_out, 32'd0);
    check("rst_cnt", {16'd0, WordCount_out}, 32'd0);
    check("rst_cnt4", {28'd0, wc4}, 32'd0);
    reset_stats();
    repeat (10) cyc();
    check("idle_reads", 32'(nreads), 32'd0);
    check("idle_rden", {31'd0, ReadEn_out}, 32'd0);
    check("idle_valid", {31'd0, Valid_out}, 32'd0);
    check("idle_cnt", {16'd0, WordCount_out}, 32'd0);

    // streaming at full rate
    reset_stats();
    Ready_in = 1'b1;
    load(8, 32'hA0);
    repeat (14) cyc();
    check("t2_reads", 32'(nreads), 32'd8);
    check("t2_latency", 32'(first_pop - first_rd), 32'd2);
    check("t2_pops", 32'(npops), 32'd8);
    check("t2_gapless", 32'(last_pop - first_pop), 32'd7);
    check("t2_cnt", {16'd0, WordCount_out}, 32'd8);

    // full backpressure, then release
    do_clear();
    reset_stats();
    Ready_in = 1'b0;
    load(8, 32'hA0);
    repeat (6) cyc();
    check("t3_reads", 32'(nreads), 32'd2);
    check("t3_valid", {31'd0, Valid_out}, 32'd1);
    check("t3_head", Data_out, 32'hA0);
    reset_stats();
    Ready_in = 1'b1;
    repeat (12) cyc();
    check("t3_pops", 32'(npops), 32'd8);
    check("t3_gapless", 32'(last_pop - first_pop), 32'd7);
    check("t3_cnt", {16'd0, WordCount_out}, 32'd8);

    // ready toggling every cycle
    do_clear();
    reset_stats();
    load(6, 32'hB0);
    for (int i = 0; i < 20; i++) begin
      Ready_in = i[0];
      cyc();
    end
    check("t4_pops", 32'(npops), 32'd6);
    check("t4_cnt", {16'd0, WordCount_out}, 32'd6);

    // counter wrap on the 4-bit instance
    do_clear();
    reset_stats();
    Ready_in = 1'b1;
    load(17, 32'hD0);
    repeat (25) cyc();
    check("t5_pops", 32'(npops), 32'd17);
    check("t5_cnt", {16'd0, WordCount_out}, 32'd17);
    check("t5_wrap4", {28'd0, wc4}, 32'd1);

    // clear the cycle after a read drops the in-flight word
    do_clear();
    reset_stats();
    Ready_in = 1'b1;
    load(4, 32'hC0);
    cyc();
    check("t6_read", 32'(nreads), 32'd1);
    Clear_in = 1'b1;
    cyc();
    Clear_in = 1'b0;
    check("t6_valid", {31'd0, Valid_out}, 32'd0);
    check("t6_cnt0", {16'd0, WordCount_out}, 32'd0);
    repeat (10) cyc();
    check("t6_pops", 32'(npops), 32'd3);
    check("t6_cnt", {16'd0, WordCount_out}, 32'd3);
    check("t6_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
